// File: rtl/alu_result_stage_if.sv
// alu_result_stage_if: upstream/downstream handshake bundle for the ALU result stage.
//   master: producer/consumer side (drives in_*, out_ready)
//   slave : the stage itself (drives in_ready, out_*)
//   out_parity exists only when ALU_RESULT_STAGE_PARITY_EN is defined.
interface alu_result_stage_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int OPCODE_WIDTH = 5
);
  logic                    in_valid;
  logic                    in_ready;
  logic [OPCODE_WIDTH-1:0] in_opcode;
  logic [DATA_WIDTH-1:0]   in_addsub;
  logic [DATA_WIDTH-1:0]   in_and;
  logic [DATA_WIDTH-1:0]   in_or;
  logic [DATA_WIDTH-1:0]   in_shift;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_WIDTH-1:0]   out_result;
  logic [OPCODE_WIDTH-1:0] out_opcode;
  logic                    out_zero;
  logic                    out_illegal;
`ifdef ALU_RESULT_STAGE_PARITY_EN
  logic                    out_parity;
`endif
  modport master (
    output in_valid, in_opcode, in_addsub, in_and, in_or, in_shift, out_ready,
    input  in_ready, out_valid, out_result, out_opcode, out_zero, out_illegal
`ifdef ALU_RESULT_STAGE_PARITY_EN
    , input out_parity
`endif
  );
  modport slave (
    input  in_valid, in_opcode, in_addsub, in_and, in_or, in_shift, out_ready,
    output in_ready, out_valid, out_result, out_opcode, out_zero, out_illegal
`ifdef ALU_RESULT_STAGE_PARITY_EN
    , output out_parity
`endif
  );
endinterface

// File: rtl/alu_result_stage.sv
// alu_result_stage: selects the ALU unit result by opcode, flags it, and buffers it in a 2-entry FIFO.
//   clock, reset : single clock, synchronous active-high reset
//   bus (slave)  : in_valid/in_ready/in_opcode/in_addsub/in_and/in_or/in_shift,
//                  out_valid/out_ready/out_result/out_opcode/out_zero/out_illegal
//   Define ALU_RESULT_STAGE_PARITY_EN to add bus.out_parity (even parity of out_result).
module alu_result_stage #(
  parameter int DATA_WIDTH   = 32,
  parameter int OPCODE_WIDTH = 5
) (
  input logic              clock,
  input logic              reset,
  alu_result_stage_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, HALF, FULL} state_t;
  state_t                  state;
  logic                    wr_ptr;
  logic                    rd_ptr;
  logic [DATA_WIDTH-1:0]   res_mem [2];
  logic [OPCODE_WIDTH-1:0] opc_mem [2];
  logic                    zero_mem [2];
  logic                    ill_mem [2];
  logic                    is_addsub;
  logic                    is_and;
  logic                    is_or;
  logic                    is_shift;
  logic                    ill;
  logic [DATA_WIDTH-1:0]   sel;
  logic                    push;
  logic                    pop;
  // opcode pairs 0/1 and 4/5 differ only in the lsb
  assign is_addsub = bus.in_opcode[OPCODE_WIDTH-1:1] == '0;
  assign is_and    = bus.in_opcode == OPCODE_WIDTH'(2);
  assign is_or     = bus.in_opcode == OPCODE_WIDTH'(3);
  assign is_shift  = bus.in_opcode[OPCODE_WIDTH-1:1] == (OPCODE_WIDTH-1)'(2);
  assign ill       = ~(is_addsub | is_and | is_or | is_shift);
  assign sel       = is_addsub ? bus.in_addsub :
                     is_and    ? bus.in_and    :
                     is_or     ? bus.in_or     :
                     is_shift  ? bus.in_shift  : '0;
  assign bus.in_ready  = (state != FULL) & ~reset;
  assign bus.out_valid = state != EMPTY;
  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;
  // storage is never cleared, so the head is masked to zero while empty
  assign bus.out_result  = bus.out_valid ? res_mem[rd_ptr] : '0;
  assign bus.out_opcode  = bus.out_valid ? opc_mem[rd_ptr] : '0;
  assign bus.out_zero    = bus.out_valid & zero_mem[rd_ptr];
  assign bus.out_illegal = bus.out_valid & ill_mem[rd_ptr];
`ifdef ALU_RESULT_STAGE_PARITY_EN
  logic par_mem [2];
  assign bus.out_parity = bus.out_valid & par_mem[rd_ptr];
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= EMPTY;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        res_mem[wr_ptr]  <= sel;
        opc_mem[wr_ptr]  <= bus.in_opcode;
        zero_mem[wr_ptr] <= sel == '0;
        ill_mem[wr_ptr]  <= ill;
`ifdef ALU_RESULT_STAGE_PARITY_EN
        par_mem[wr_ptr]  <= ^sel;
`endif
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      state <= (push & ~pop) ? (state == EMPTY ? HALF : FULL) :
               (pop & ~push) ? (state == FULL ? HALF : EMPTY) : state;
    end
  end
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed and randomized checks of alu_result_stage against a queue model.
module tb_alu_result_stage;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  alu_result_stage_if #(.DATA_WIDTH(32), .OPCODE_WIDTH(5)) bus ();
  alu_result_stage #(.DATA_WIDTH(32), .OPCODE_WIDTH(5)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );
  typedef struct {
    logic [31:0] r;
    logic [4:0]  op;
    logic        z;
    logic        il;
  } ent_t;
  ent_t q[$];
  int nvec = 0;
  int nerr = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic ent_t ref_entry(input logic [4:0] op, input logic [31:0] a, input logic [31:0] n,
                                     input logic [31:0] o, input logic [31:0] s);
    ent_t e;
    e.op = op;
    e.il = 1'b0;
    if (op <= 5'd1) e.r = a;
    else if (op == 5'd2) e.r = n;
    else if (op == 5'd3) e.r = o;
    else if (op <= 5'd5) e.r = s;
    else begin
      e.r  = 32'h0;
      e.il = 1'b1;
    end
    e.z = (e.r == 32'h0);
    return e;
  endfunction
  task automatic check_outputs();
    ent_t h;
    logic v;
    v = q.size() != 0;
    h.r = 32'h0; h.op = 5'h0; h.z = 1'b0; h.il = 1'b0;
    if (v) h = q[0];
    chk("in_ready",    32'(bus.in_ready),    32'(q.size() < 2 && !reset));
    chk("out_valid",   32'(bus.out_valid),   32'(v));
    chk("out_result",  bus.out_result,       h.r);
    chk("out_opcode",  32'(bus.out_opcode),  32'(h.op));
    chk("out_zero",    32'(bus.out_zero),    32'(h.z));
    chk("out_illegal", 32'(bus.out_illegal), 32'(h.il));
`ifdef ALU_RESULT_STAGE_PARITY_EN
    chk("out_parity",  32'(bus.out_parity),  32'(v && (^h.r)));
`endif
  endtask
  // drive one cycle at the falling edge, check just after, advance the model at the rising edge
  task automatic cycle(input logic iv, input logic [4:0] op, input logic [31:0] a, input logic [31:0] n,
                       input logic [31:0] o, input logic [31:0] s, input logic ordy, input logic rs);
    logic do_push;
    logic do_pop;
    reset         = rs;
    bus.in_valid  = iv;
    bus.in_opcode = op;
    bus.in_addsub = a;
    bus.in_and    = n;
    bus.in_or     = o;
    bus.in_shift  = s;
    bus.out_ready = ordy;
    #1;
    check_outputs();
    do_push = iv && q.size() < 2 && !rs;
    do_pop  = q.size() > 0 && ordy && !rs;
    @(posedge clock);
    if (rs) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(ref_entry(op, a, n, o, s));
    end
    @(negedge clock);
  endtask
  task automatic idle(input logic ordy);
    cycle(1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, ordy, 1'b0);
  endtask
  task automatic push_op(input logic [4:0] op, input logic [31:0] d, input logic ordy);
    cycle(1'b1, op, d, ~d, d ^ 32'h5A5A_A5A5, {d[15:0], d[31:16]}, ordy, 1'b0);
  endtask
  initial begin
    bus.in_valid = 1'b0; bus.in_opcode = 5'h0; bus.in_addsub = 32'h0; bus.in_and = 32'h0;
    bus.in_or = 32'h0; bus.in_shift = 32'h0; bus.out_ready = 1'b0;
    @(negedge clock);
    cycle(1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    idle(1'b0);
    chk("t1_in_ready", 32'(bus.in_ready), 32'd1);
    chk("t1_out_valid", 32'(bus.out_valid), 32'd0);
    cycle(1'b1, 5'd3, 32'h1111_1111, 32'h2222_2222, 32'hF0F0_0F0F, 32'h3333_3333, 1'b1, 1'b0);
    chk("t2_result", bus.out_result, 32'hF0F0_0F0F);
    idle(1'b1);
    chk("t2_empty", 32'(bus.out_valid), 32'd0);
    cycle(1'b1, 5'd2, 32'h7, 32'h0, 32'h9, 32'hA, 1'b0, 1'b0);
    cycle(1'b1, 5'd0, 32'h5, 32'h6, 32'h7, 32'h8, 1'b0, 1'b0);
    cycle(1'b1, 5'd3, 32'h1, 32'h2, 32'h3, 32'h4, 1'b0, 1'b0);
    chk("t3_full_in_ready", 32'(bus.in_ready), 32'd0);
    idle(1'b1);
    chk("t3_second", bus.out_result, 32'h5);
    idle(1'b1);
    push_op(5'd1, 32'hDEAD_0001, 1'b0);
    for (int i = 0; i < 8; i++) push_op(5'(i % 6), 32'h1000_0000 + 32'(i), 1'b1);
    chk("t4_half", 32'(q.size()), 32'd1);
    idle(1'b1);
    idle(1'b1);
    push_op(5'd31, 32'h1234_5678, 1'b0);
    chk("t5_illegal", 32'(bus.out_illegal), 32'd1);
    idle(1'b1);
    push_op(5'd4, 32'hCAFE_0001, 1'b0);
    push_op(5'd2, 32'h0000_00FF, 1'b0);
    cycle(1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    idle(1'b0);
    chk("t6_after_reset", bus.out_result, 32'h0);
    push_op(5'd0, 32'h0000_0001, 1'b0);
`ifdef ALU_RESULT_STAGE_PARITY_EN
    chk("t6_parity", 32'(bus.out_parity), 32'd1);
`endif
    idle(1'b1);
    for (int i = 0; i < 400; i++) begin
      logic [4:0]  op;
      logic [31:0] a, n, o, s;
      op = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      a = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom();
      n = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom();
      o = $urandom();
      s = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom();
      cycle($urandom_range(0, 3) != 0, op, a, n, o, s, $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
